omsp_alu_addc_seq: RTL and testbench

//  Sequencer/arbiter for the shared 16-bit ALU adder (sum[16:0] = a + b + cin).
//  Two requesters (r0: CPU multi-word ADDC/SUBC helper, r1: hardware-MAC accumulate)

---
 rtl/omsp_alu_addc_seq.sv | 189 ++++++++++++++++++
 tb/tb_omsp_alu_addc_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_alu_addc_seq.sv
// Sequencer/arbiter for the shared 16-bit ALU adder: grants one of two requesters,
// streams its operand words LSW first with carry chaining, returns words and flags.
module omsp_alu_addc_seq #(
  parameter int unsigned MAXW = 4
) (
  input  logic                      mclk,
  input  logic                      puc_rst,
  input  logic                      r0_req,
  input  logic                      r0_sub,
  input  logic [$clog2(MAXW)-1:0]   r0_nw,
  input  logic                      r0_cin,
  input  logic [15:0]               r0_a,
  input  logic [15:0]               r0_b,
  output logic                      r0_beat,
  output logic                      r0_done,
  input  logic                      r1_req,
  input  logic                      r1_sub,
  input  logic [$clog2(MAXW)-1:0]   r1_nw,
  input  logic                      r1_cin,
  input  logic [15:0]               r1_a,
  input  logic [15:0]               r1_b,
  output logic                      r1_beat,
  output logic                      r1_done,
  output logic [$clog2(MAXW)-1:0]   beat_idx,
  output logic [15:0]               add_a,
  output logic [15:0]               add_b,
  output logic                      add_cin,
  input  logic [16:0]               add_sum,
  output logic [15:0]               res_word,
  output logic                      res_vld,
  output logic                      res_c,
  output logic                      res_z,
  output logic                      res_n,
  output logic                      res_v,
  output logic                      busy
);

  localparam int unsigned NWW = $clog2(MAXW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic             sub_q, sub_d;
  logic [NWW-1:0]   nw_q, nw_d;
  logic             carry_q, carry_d;
  logic [NWW-1:0]   beat_idx_q, beat_idx_d;
  logic             zacc_q, zacc_d;
  logic [15:0]      res_word_q, res_word_d;
  logic             res_vld_q, res_vld_d;
  logic             res_c_q, res_c_d;
  logic             res_z_q, res_z_d;
  logic             res_n_q, res_n_d;
  logic             res_v_q, res_v_d;

  logic             req_g;
  logic [15:0]      a_g;
  logic [15:0]      b_g;
  logic             beat;
  logic             done;
  logic             sum_zero;

  assign req_g    = gnt_q ? r1_req : r0_req;
  assign a_g      = gnt_q ? r1_a   : r0_a;
  assign b_g      = gnt_q ? r1_b   : r0_b;
  assign sum_zero = (add_sum[15:0] == '0);

  // Adder drive kept apart from next-state logic so the external adder path
  // does not form a false combinational loop through one process.
  always_comb begin
    beat    = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN && req_g) begin
      beat    = 1'b1;
      add_a   = a_g;
      add_b   = sub_q ? ~b_g : b_g;
      add_cin = carry_q;
    end
    if (state_q == S_DONE) done = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    sub_d      = sub_q;
    nw_d       = nw_q;
    carry_d    = carry_q;
    beat_idx_d = beat_idx_q;
    zacc_d     = zacc_q;
    res_word_d = res_word_q;
    res_vld_d  = 1'b0;
    res_c_d    = res_c_q;
    res_z_d    = res_z_q;
    res_n_d    = res_n_q;
    res_v_d    = res_v_q;
    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d      = (r0_req && r1_req) ? ~last_gnt_q : r1_req;
          sub_d      = gnt_d ? r1_sub : r0_sub;
          nw_d       = gnt_d ? r1_nw  : r0_nw;
          carry_d    = gnt_d ? r1_cin : r0_cin;
          beat_idx_d = '0;
          zacc_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (!req_g) begin
          state_d    = S_IDLE;
          carry_d    = 1'b0;
          beat_idx_d = '0;
        end else begin
          carry_d    = add_sum[16];
          res_word_d = add_sum[15:0];
          res_vld_d  = 1'b1;
          zacc_d     = zacc_q & sum_zero;
          if (beat_idx_q == nw_q) begin
            state_d = S_DONE;
            res_c_d = add_sum[16];
            res_z_d = zacc_q & sum_zero;
            res_n_d = add_sum[15];
            res_v_d = (a_g[15] == add_b[15]) && (add_sum[15] != a_g[15]);
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        last_gnt_d = gnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      sub_q      <= 1'b0;
      nw_q       <= '0;
      carry_q    <= 1'b0;
      beat_idx_q <= '0;
      zacc_q     <= 1'b0;
      res_word_q <= '0;
      res_vld_q  <= 1'b0;
      res_c_q    <= 1'b0;
      res_z_q    <= 1'b0;
      res_n_q    <= 1'b0;
      res_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      sub_q      <= sub_d;
      nw_q       <= nw_d;
      carry_q    <= carry_d;
      beat_idx_q <= beat_idx_d;
      zacc_q     <= zacc_d;
      res_word_q <= res_word_d;
      res_vld_q  <= res_vld_d;
      res_c_q    <= res_c_d;
      res_z_q    <= res_z_d;
      res_n_q    <= res_n_d;
      res_v_q    <= res_v_d;
    end
  end

  assign r0_beat  = beat & ~gnt_q;
  assign r1_beat  = beat &  gnt_q;
  assign r0_done  = done & ~gnt_q;
  assign r1_done  = done &  gnt_q;
  assign beat_idx = beat_idx_q;
  assign res_word = res_word_q;
  assign res_vld  = res_vld_q;
  assign res_c    = res_c_q;
  assign res_z    = res_z_q;
  assign res_n    = res_n_q;
  assign res_v    = res_v_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_omsp_alu_addc_seq.sv
// Bench for omsp_alu_addc_seq: behavioural adder, vector table, arbitration,
// abort and reset sequences, with a word/flag scoreboard.
module tb_omsp_alu_addc_seq;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        r0_req, r0_sub, r0_cin, r1_req, r1_sub, r1_cin;
  logic [1:0]  r0_nw, r1_nw, beat_idx;
  logic [15:0] r0_a, r0_b, r1_a, r1_b, add_a, add_b, res_word;
  logic        r0_beat, r0_done, r1_beat, r1_done, add_cin;
  logic        res_vld, res_c, res_z, res_n, res_v, busy;
  logic [16:0] add_sum;

  logic [15:0] op_a [2][4];
  logic [15:0] op_b [2][4];

  int checks = 0;
  int fails  = 0;
  int done1_cnt = 0;

  typedef struct packed {
    logic             id;
    logic             sub;
    logic [1:0]       nw;
    logic             cin;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][15:0] w;
    logic [3:0]       f;   // {c,z,n,v}
  } job_t;

  logic [16:0] wq [$];
  logic [4:0]  fq [$];
  logic [16:0] we;
  logic [4:0]  fe;

  always #5 mclk = ~mclk;

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
  assign r0_a = op_a[0][beat_idx];
  assign r0_b = op_b[0][beat_idx];
  assign r1_a = op_a[1][beat_idx];
  assign r1_b = op_b[1][beat_idx];

  omsp_alu_addc_seq #(.MAXW(4)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .r0_req(r0_req), .r0_sub(r0_sub), .r0_nw(r0_nw), .r0_cin(r0_cin),
    .r0_a(r0_a), .r0_b(r0_b), .r0_beat(r0_beat), .r0_done(r0_done),
    .r1_req(r1_req), .r1_sub(r1_sub), .r1_nw(r1_nw), .r1_cin(r1_cin),
    .r1_a(r1_a), .r1_b(r1_b), .r1_beat(r1_beat), .r1_done(r1_done),
    .beat_idx(beat_idx), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .res_word(res_word), .res_vld(res_vld),
    .res_c(res_c), .res_z(res_z), .res_n(res_n), .res_v(res_v), .busy(busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic job_t mk(input logic id, input logic sub, input logic [1:0] nw,
                              input logic cin, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] w, input logic [3:0] f);
    job_t j;
    j.id = id; j.sub = sub; j.nw = nw; j.cin = cin;
    j.a = a; j.b = b; j.w = w; j.f = f;
    return j;
  endfunction

  // Reference arithmetic: word-serial add with carry chaining.
  function automatic job_t model(input job_t j);
    logic [16:0] s;
    logic [15:0] bb;
    logic        c = j.cin;
    logic        z = 1'b1;
    for (int i = 0; i <= int'(j.nw); i++) begin
      bb = j.sub ? ~j.b[i] : j.b[i];
      s  = {1'b0, j.a[i]} + {1'b0, bb} + {16'b0, c};
      j.w[i] = s[15:0];
      z = z & (s[15:0] == 16'h0000);
      c = s[16];
      if (i == int'(j.nw))
        j.f = {s[16], z, s[15], (j.a[i][15] == bb[15]) && (s[15] != j.a[i][15])};
    end
    return j;
  endfunction

  function automatic job_t rnd_job(input logic id, input logic [1:0] nw);
    job_t j = '0;
    j.id = id; j.nw = nw; j.sub = 1'($urandom); j.cin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      j.a[i] = 16'($urandom);
      j.b[i] = 16'($urandom);
    end
    return j;
  endfunction

  task automatic push_exp(input job_t m);
    for (int i = 0; i <= int'(m.nw); i++) wq.push_back({m.id, m.w[i]});
    fq.push_back({m.id, m.f});
  endtask

  task automatic load(input job_t j);
    for (int i = 0; i < 4; i++) begin
      op_a[j.id][i] = j.a[i];
      op_b[j.id][i] = j.b[i];
    end
    if (j.id) begin r1_sub = j.sub; r1_nw = j.nw; r1_cin = j.cin; r1_req = 1'b1; end
    else      begin r0_sub = j.sub; r0_nw = j.nw; r0_cin = j.cin; r0_req = 1'b1; end
  endtask

  // Raise a request at a falling edge and hold it until its done pulse.
  task automatic run_req(input job_t j, input int lat);
    int  n = 0;
    int  bi = 0;
    bit  seen = 0;
    load(j);
    while (!seen && n < 200) begin
      @(negedge mclk);
      n++;
      if (j.id ? r1_beat : r0_beat) begin
        check("beat_idx", 32'(beat_idx), 32'(bi));
        bi++;
      end
      if (j.id ? r1_done : r0_done) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("beat_count", 32'(bi), 32'(j.nw) + 32'd1);
    if (lat > 0) check("done_latency", 32'(n), 32'(lat));
    if (j.id) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  always @(negedge mclk) begin
    if (!puc_rst) begin
      if (busy) check("single_beat", 32'(r0_beat & r1_beat), 32'd0);
      if (res_vld) begin
        if (wq.size() == 0) check("unexpected_res_vld", 32'd1, 32'd0);
        else begin
          we = wq.pop_front();
          check("res_word", 32'(res_word), 32'(we[15:0]));
        end
      end
      if (r1_done) done1_cnt++;
      if (r0_done || r1_done) begin
        if (fq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          fe = fq.pop_front();
          check("done_id_flags", 32'({r1_done, res_c, res_z, res_n, res_v}), 32'(fe));
        end
      end
    end
  end

  job_t tbl [7];
  job_t j0, j1, j2;
  int   n;
  int   d1;

  initial begin
    tbl[0] = mk(0, 0, 1, 0, {16'h0, 16'h0, 16'h0001, 16'hFFFF}, {16'h0, 16'h0, 16'h0000, 16'h0001},
                {16'h0, 16'h0, 16'h0002, 16'h0000}, 4'b0000);
    tbl[1] = mk(1, 1, 0, 1, {48'h0, 16'h8000}, {48'h0, 16'h0001}, {48'h0, 16'h7FFF}, 4'b1001);
    tbl[2] = mk(0, 0, 3, 0, 64'h0, 64'h0, 64'h0, 4'b0100);
    tbl[3] = mk(1, 0, 0, 0, {48'h0, 16'h7FFF}, {48'h0, 16'h0001}, {48'h0, 16'h8000}, 4'b0011);
    tbl[4] = mk(0, 1, 1, 1, 64'h0, {16'h0, 16'h0, 16'h0000, 16'h0001},
                {16'h0, 16'h0, 16'hFFFF, 16'hFFFF}, 4'b0010);
    tbl[5] = mk(1, 0, 2, 1, {16'h0, 16'h0000, 16'hFFFF, 16'hFFFF}, 64'h0,
                {16'h0, 16'h0001, 16'h0000, 16'h0000}, 4'b0000);
    tbl[6] = mk(0, 1, 0, 1, {48'h0, 16'h1234}, {48'h0, 16'h1234}, {48'h0, 16'h0000}, 4'b1100);

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin op_a[i][k] = '0; op_b[i][k] = '0; end
    puc_rst = 1'b1;
    r0_req = 0; r0_sub = 0; r0_nw = 0; r0_cin = 0;
    r1_req = 0; r1_sub = 0; r1_nw = 0; r1_cin = 0;
    repeat (2) @(negedge mclk);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_res",     32'({res_vld, res_word}), 32'd0);
    check("rst_flags",   32'({res_c, res_z, res_n, res_v}), 32'd0);
    check("rst_done",    32'({r0_done, r1_done, r0_beat, r1_beat}), 32'd0);
    check("rst_adder",   32'({add_cin, add_a, add_b} != 33'd0), 32'd0);
    check("rst_beatidx", 32'(beat_idx), 32'd0);
    puc_rst = 1'b0;
    @(negedge mclk);

    // Vector table: single requester jobs from IDLE, latency nw+2 falling edges.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k <= int'(tbl[i].nw); k++) wq.push_back({tbl[i].id, tbl[i].w[k]});
      fq.push_back({tbl[i].id, tbl[i].f});
      run_req(tbl[i], int'(tbl[i].nw) + 2);
      @(negedge mclk);
      check("idle_after_job", 32'(busy), 32'd0);
      check("adder_idle", 32'({add_a, add_b} != 32'd0), 32'd0);
    end

    // Reset mid-job: flags from the last table entry are nonzero beforehand.
    j0 = model(rnd_job(0, 3));
    wq.push_back({1'b0, j0.w[0]});
    wq.push_back({1'b0, j0.w[1]});
    load(j0);
    n = 0;
    do begin @(negedge mclk); n++; end while (!(r0_beat && beat_idx == 2'd2) && n < 20);
    check("reach_beat2", 32'(n < 20), 32'd1);
    #2 puc_rst = 1'b1; r0_req = 1'b0;
    #1;
    check("rst_mid_busy",  32'(busy), 32'd0);
    check("rst_mid_vld",   32'(res_vld), 32'd0);
    check("rst_mid_flags", 32'({res_c, res_z, res_n, res_v}), 32'd0);
    check("rst_mid_out",   32'({r0_beat, beat_idx, res_word}), 32'd0);
    @(negedge mclk);
    puc_rst = 1'b0;
    @(negedge mclk);

    // Arbitration after reset: r0 first, then r1, then r0 again.
    j0 = model(mk(0, 0, 0, 0, {48'h0, 16'h1111}, {48'h0, 16'h2222}, 64'h0, 4'h0));
    j1 = model(rnd_job(1, 1));
    j2 = model(rnd_job(0, 1));
    push_exp(j0); push_exp(j1); push_exp(j2);
    fork
      begin run_req(j0, 2); @(negedge mclk); run_req(j2, -1); end
      begin run_req(j1, -1); end
    join
    @(negedge mclk);

    // Abort: r1 drops request at beat_idx 1 while r0 waits.
    j1 = model(rnd_job(1, 3));
    j0 = model(rnd_job(0, 0));
    wq.push_back({1'b1, j1.w[0]});
    push_exp(j0);
    d1 = done1_cnt;
    load(j1);
    @(negedge mclk);
    check("abort_beat0", 32'({r1_beat, beat_idx}), 32'b100);
    load(j0);
    @(negedge mclk);
    check("abort_beat1", 32'({r1_beat, r0_beat, beat_idx}), 32'b1001);
    r1_req = 1'b0;
    #1 check("abort_no_beat", 32'(r1_beat | r0_beat), 32'd0);
    @(negedge mclk);
    check("abort_idle", 32'({busy, res_vld}), 32'd0);
    n = 0;
    do begin @(negedge mclk); n++; end while (!r0_done && n < 20);
    check("pending_r0_latency", 32'(n), 32'd2);
    r0_req = 1'b0;
    check("abort_no_r1_done", 32'(done1_cnt), 32'(d1));
    repeat (3) @(negedge mclk);

    check("words_drained", 32'(wq.size()), 32'd0);
    check("flags_drained", 32'(fq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
